// File: rtl/iob_axis_arb_pkg.sv
// iob_axis_arb_pkg
// Shared definitions for the IOB-to-AXIS round-robin arbiter:
//   - arb_state_e : arbiter FSM states (IDLE = 1'b0, GRANT = 1'b1)
//   - idx_width   : width of a requester index for a given requester count
//   - cnt_width   : width of the burst counter, able to hold 0..BURST_MAX
// Optional feature macro used by the arbiter: IOB_AXIS_ARB_BURST_EN.

package iob_axis_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int idx_width(input int nReq);
        return (nReq > 1) ? $clog2(nReq) : 1;
    endfunction

    function automatic int cnt_width(input int burstMax);
        return $clog2(burstMax + 1);
    endfunction

endpackage

// File: rtl/iob_axis_arb_rr.sv
// iob_axis_arb_rr
// Combinational rotating-priority picker. Returns the first set request bit
// at or after ptr_i, wrapping around past the top requester.
// Ports:
//   req_i [N_REQ]  : request vector, bit k = requester k
//   ptr_i [IDX_W]  : requester with highest priority this cycle
//   idx_o [IDX_W]  : selected requester (0 when nothing is requested)
//   any_o          : at least one request bit is set

module iob_axis_arb_rr #(
    parameter int N_REQ = 2,
    parameter int IDX_W = 1
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [2*N_REQ-1:0] reqRot;

    // Rotate the request vector so bit i of reqRot is requester (ptr+i) mod N,
    // then scan from the far end downwards so the closest-to-ptr request wins.
    always_comb begin
        reqRot = {req_i, req_i} >> ptr_i;
        idx_o  = '0;
        any_o  = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (reqRot[i]) begin
                idx_o = IDX_W'((int'(ptr_i) + i) % N_REQ);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_axis_arb.sv
// iob_axis_arb
// Round-robin arbiter sharing one IOB-to-AXI-Stream channel between N_REQ IOB
// requesters. Writes (non-zero strobes) drive the AXIS master side, reads
// (zero strobes) pull from the AXIS slave side. Grants are registered; read
// data returns one cycle after acceptance to the requester that issued it.
// Optional feature: define IOB_AXIS_ARB_BURST_EN to hold a grant for up to
// BURST_MAX accepted transfers; otherwise every accepted transfer releases.
// Ports:
//   clk_i, rst_n_i (sync, active-low), cke_i (state holds when low)
//   valid_i/wstrb_i/wdata_i : flattened per-requester IOB request buses
//   ready_o/rvalid_o        : per-requester accept and read-data valid
//   rdata_o                 : shared read data, qualified by rvalid_o
//   tdata_o/tvalid_o/tready_i : AXIS write channel
//   tdata_i/tvalid_i/tready_o : AXIS read channel

module iob_axis_arb
    import iob_axis_arb_pkg::*;
#(
    parameter int N_REQ     = 2,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         cke_i,
    input  logic [N_REQ-1:0]             valid_i,
    input  logic [N_REQ*(DATA_W/8)-1:0]  wstrb_i,
    input  logic [N_REQ*DATA_W-1:0]      wdata_i,
    output logic [N_REQ-1:0]             ready_o,
    output logic [N_REQ-1:0]             rvalid_o,
    output logic [DATA_W-1:0]            rdata_o,
    output logic [DATA_W-1:0]            tdata_o,
    output logic                         tvalid_o,
    input  logic                         tready_i,
    input  logic [DATA_W-1:0]            tdata_i,
    input  logic                         tvalid_i,
    output logic                         tready_o
);

    localparam int STRB_W = DATA_W / 8;
    localparam int IDX_W  = idx_width(N_REQ);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [IDX_W-1:0]  gnt_idx_q, gnt_idx_d;
    logic [IDX_W-1:0]  rv_idx_q, rv_idx_d;
    logic              rv_q, rv_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;

    logic              gValid;
    logic [STRB_W-1:0] gStrb;
    logic [DATA_W-1:0] gData;
    logic              gWrite;
    logic              granted;
    logic              accept;
    logic              burstLast;
    logic              pickAny;
    logic [IDX_W-1:0]  pickIdx;
    logic [IDX_W-1:0]  nextPtr;

`ifdef IOB_AXIS_ARB_BURST_EN
    localparam int CNT_W = cnt_width(BURST_MAX);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    iob_axis_arb_rr #(
        .N_REQ(N_REQ),
        .IDX_W(IDX_W)
    ) u_rr (
        .req_i(valid_i),
        .ptr_i(ptr_q),
        .idx_o(pickIdx),
        .any_o(pickAny)
    );

    // Select the granted requester's slice of each flattened bus and forward
    // it to the AXIS side; everything reads as zero while idle.
    always_comb begin
        gValid = 1'b0;
        gStrb  = '0;
        gData  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (gnt_idx_q == IDX_W'(k)) begin
                gValid = valid_i[k];
                gStrb  = wstrb_i[k*STRB_W +: STRB_W];
                gData  = wdata_i[k*DATA_W +: DATA_W];
            end
        end
        granted  = (state_q == GRANT);
        gWrite   = |gStrb;
        tvalid_o = granted & gValid & gWrite;
        tready_o = granted & gValid & ~gWrite;
        tdata_o  = granted ? gData : '0;
        for (int k = 0; k < N_REQ; k++) begin
            ready_o[k]  = granted && (gnt_idx_q == IDX_W'(k)) &&
                          (gWrite ? tready_i : tvalid_i);
            rvalid_o[k] = rv_q && (rv_idx_q == IDX_W'(k));
        end
        accept = granted & gValid & (gWrite ? tready_i : tvalid_i);
    end

    assign rdata_o = rdata_q;

    // Next-state logic. The read-return index is captured with the data so a
    // read accepted on the releasing cycle still returns to its requester.
    always_comb begin
        nextPtr   = (gnt_idx_q == IDX_W'(N_REQ - 1)) ? '0 : gnt_idx_q + 1'b1;
`ifdef IOB_AXIS_ARB_BURST_EN
        burstLast = (cnt_q == CNT_W'(BURST_MAX - 1));
        cnt_d     = cnt_q;
`else
        burstLast = 1'b1;
`endif
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        rv_d      = 1'b0;
        rv_idx_d  = rv_idx_q;
        rdata_d   = rdata_q;
        case (state_q)
            IDLE: begin
                if (pickAny) begin
                    state_d   = GRANT;
                    gnt_idx_d = pickIdx;
`ifdef IOB_AXIS_ARB_BURST_EN
                    cnt_d     = '0;
`endif
                end
            end
            GRANT: begin
                if (accept && !gWrite) begin
                    rv_d     = 1'b1;
                    rv_idx_d = gnt_idx_q;
                    rdata_d  = tdata_i;
                end
`ifdef IOB_AXIS_ARB_BURST_EN
                if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
                if (!gValid || (accept && burstLast)) begin
                    state_d = IDLE;
                    ptr_d   = nextPtr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All arbiter state; reset wins over the clock enable.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_idx_q <= '0;
            rv_q      <= 1'b0;
            rv_idx_q  <= '0;
            rdata_q   <= '0;
`ifdef IOB_AXIS_ARB_BURST_EN
            cnt_q     <= '0;
`endif
        end else if (cke_i) begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            rv_q      <= rv_d;
            rv_idx_q  <= rv_idx_d;
            rdata_q   <= rdata_d;
`ifdef IOB_AXIS_ARB_BURST_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_iob_axis_arb.sv
// tb_iob_axis_arb
// Testbench for iob_axis_arb with N_REQ=3, DATA_W=32, BURST_MAX=4.
// Directed table rows, a burst rotation sequence and randomized traffic are
// compared against a transaction-level reference model. Works with or without
// IOB_AXIS_ARB_BURST_EN defined.

module tb_iob_axis_arb;

    localparam int N     = 3;
    localparam int DW    = 32;
    localparam int BMAX  = 4;
`ifdef IOB_AXIS_ARB_BURST_EN
    localparam int LIMIT = BMAX;
`else
    localparam int LIMIT = 1;
`endif

    logic            clk;
    logic            rstN;
    logic            cke;
    logic [N-1:0]    valid;
    logic [N*4-1:0]  wstrb;
    logic [N*DW-1:0] wdata;
    logic [N-1:0]    readyO;
    logic [N-1:0]    rvalidO;
    logic [DW-1:0]   rdataO;
    logic [DW-1:0]   tdataO;
    logic            tvalidO;
    logic            treadyIn;
    logic [DW-1:0]   tdataIn;
    logic            tvalidIn;
    logic            treadyO;

    int nVectors = 0;
    int nMiscompares = 0;

    // Reference model state
    bit          mGranted;
    int          mOwner;
    int          mPtr;
    int          mCount;
    bit          mRvPend;
    int          mRvWho;
    logic [31:0] mRdata;

    logic [N-1:0]  eReady;
    logic [N-1:0]  eRvalid;
    logic [DW-1:0] eRdata;
    logic [DW-1:0] eTdata;
    logic          eTvalid;
    logic          eTready;

    typedef struct packed {
        logic            rstN;
        logic [N-1:0]    valid;
        logic [N*4-1:0]  wstrb;
        logic [N*DW-1:0] wdata;
        logic            tready;
        logic            tvalid;
        logic [DW-1:0]   tdata;
        logic [N-1:0]    xReady;
        logic            xTvalid;
        logic [DW-1:0]   xTdata;
        logic            xTready;
        logic [N-1:0]    xRvalid;
        logic [DW-1:0]   xRdata;
    } vec_t;

    vec_t tbl[24];

    iob_axis_arb #(
        .N_REQ(N),
        .DATA_W(DW),
        .BURST_MAX(BMAX)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rstN),
        .cke_i(cke),
        .valid_i(valid),
        .wstrb_i(wstrb),
        .wdata_i(wdata),
        .ready_o(readyO),
        .rvalid_o(rvalidO),
        .rdata_o(rdataO),
        .tdata_o(tdataO),
        .tvalid_o(tvalidO),
        .tready_i(treadyIn),
        .tdata_i(tdataIn),
        .tvalid_i(tvalidIn),
        .tready_o(treadyO)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkRow(
        input logic r, input logic [N-1:0] v, input logic [N*4-1:0] s,
        input logic [N*DW-1:0] d, input logic tr, input logic tv,
        input logic [DW-1:0] td, input logic [N-1:0] xr, input logic xtv,
        input logic [DW-1:0] xtd, input logic xtr, input logic [N-1:0] xrv,
        input logic [DW-1:0] xrd);
        vec_t t;
        t.rstN = r;  t.valid = v;  t.wstrb = s;  t.wdata = d;
        t.tready = tr; t.tvalid = tv; t.tdata = td;
        t.xReady = xr; t.xTvalid = xtv; t.xTdata = xtd; t.xTready = xtr;
        t.xRvalid = xrv; t.xRdata = xrd;
        return t;
    endfunction

    task automatic checkSig(input string name, input logic [31:0] act,
                            input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t t);
        rstN     = t.rstN;
        cke      = 1'b1;
        valid    = t.valid;
        wstrb    = t.wstrb;
        wdata    = t.wdata;
        treadyIn = t.tready;
        tvalidIn = t.tvalid;
        tdataIn  = t.tdata;
    endtask

    // Expected combinational outputs from the model's view of who owns the channel
    task automatic modelOutputs();
        logic [3:0] s;
        eReady  = '0;
        eTvalid = 1'b0;
        eTready = 1'b0;
        eTdata  = '0;
        if (mGranted) begin
            s       = wstrb[mOwner*4 +: 4];
            eTvalid = valid[mOwner] && (s != 0);
            eTready = valid[mOwner] && (s == 0);
            eTdata  = wdata[mOwner*DW +: DW];
            eReady[mOwner] = (s != 0) ? treadyIn : tvalidIn;
        end
        eRvalid = mRvPend ? N'(1 << mRvWho) : '0;
        eRdata  = mRdata;
    endtask

    // Advance the model by one clock edge using the inputs present at the edge
    task automatic modelEdge();
        bit v;
        bit wr;
        bit acc;
        int k;
        if (!rstN) begin
            mGranted = 0; mOwner = 0; mPtr = 0; mCount = 0;
            mRvPend = 0; mRvWho = 0; mRdata = '0;
        end else if (cke) begin
            if (!mGranted) begin
                mRvPend = 0;
                for (int off = 0; off < N; off++) begin
                    k = (mPtr + off) % N;
                    if (valid[k] && !mGranted) begin
                        mGranted = 1;
                        mOwner   = k;
                        mCount   = 0;
                    end
                end
            end else begin
                v   = valid[mOwner];
                wr  = (wstrb[mOwner*4 +: 4] != 0);
                acc = v && (wr ? treadyIn : tvalidIn);
                mRvPend = acc && !wr;
                if (acc && !wr) begin
                    mRvWho = mOwner;
                    mRdata = tdataIn;
                end
                if (acc) mCount++;
                if (!v || mCount >= LIMIT) begin
                    mGranted = 0;
                    mPtr     = (mOwner + 1) % N;
                end
            end
        end
    endtask

    task automatic checkOutput();
        modelOutputs();
        checkSig("model.ready_o",  32'(readyO),  32'(eReady));
        checkSig("model.rvalid_o", 32'(rvalidO), 32'(eRvalid));
        checkSig("model.rdata_o",  rdataO,       eRdata);
        checkSig("model.tdata_o",  tdataO,       eTdata);
        checkSig("model.tvalid_o", 32'(tvalidO), 32'(eTvalid));
        checkSig("model.tready_o", 32'(treadyO), 32'(eTready));
    endtask

    task automatic checkRow(input int i, input vec_t t);
        string p;
        p = $sformatf("row%0d.", i);
        checkSig({p, "ready_o"},  32'(readyO),  32'(t.xReady));
        checkSig({p, "tvalid_o"}, 32'(tvalidO), 32'(t.xTvalid));
        checkSig({p, "tdata_o"},  tdataO,       t.xTdata);
        checkSig({p, "tready_o"}, 32'(treadyO), 32'(t.xTready));
        checkSig({p, "rvalid_o"}, 32'(rvalidO), 32'(t.xRvalid));
        checkSig({p, "rdata_o"},  rdataO,       t.xRdata);
    endtask

    task automatic advance();
        @(posedge clk);
        modelEdge();
        #1;
    endtask

    initial begin
        logic [N-1:0] want;
        int pos;
        int own;

        // Requester slices: req0 = LSB. strobes F per requester.
        tbl[0]  = mkRow(0, 3'b111, 12'hFFF, {3{32'hFFFF_FFFF}}, 1, 0, 0,
                        0, 0, 0, 0, 0, 0);
        tbl[1]  = tbl[0];
        tbl[2]  = tbl[0];
        tbl[3]  = mkRow(1, 3'b111, 12'hFFF, '0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mkRow(1, 3'b001, 12'h00F, {64'h0, 32'hCAFE_0000}, 0, 0, 0,
                        3'b000, 1, 32'hCAFE_0000, 0, 0, 0);
        tbl[5]  = mkRow(1, 3'b000, 12'h000, '0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mkRow(1, 3'b010, 12'h0F0, {32'h0, 32'hA5A5_A5A5, 32'h0}, 1, 0, 0,
                        0, 0, 0, 0, 0, 0);
        tbl[7]  = mkRow(1, 3'b010, 12'h0F0, {32'h0, 32'hA5A5_A5A5, 32'h0}, 1, 0, 0,
                        3'b010, 1, 32'hA5A5_A5A5, 0, 0, 0);
        tbl[8]  = tbl[5];
        tbl[9]  = mkRow(1, 3'b001, 12'h000, '0, 0, 1, 32'h1234_5678,
                        0, 0, 0, 0, 0, 0);
        tbl[10] = mkRow(1, 3'b001, 12'h000, '0, 0, 1, 32'h1234_5678,
                        3'b001, 0, 0, 1, 0, 0);
        tbl[11] = mkRow(1, 3'b000, 12'h000, '0, 0, 0, 0,
                        0, 0, 0, 0, 3'b001, 32'h1234_5678);
        tbl[12] = mkRow(1, 3'b000, 12'h000, '0, 0, 0, 0,
                        0, 0, 0, 0, 0, 32'h1234_5678);
        tbl[13] = mkRow(1, 3'b100, 12'hF00, {32'hDEAD_BEEF, 64'h0}, 0, 0, 0,
                        0, 0, 0, 0, 0, 32'h1234_5678);
        for (int i = 14; i <= 18; i++)
            tbl[i] = mkRow(1, 3'b100, 12'hF00, {32'hDEAD_BEEF, 64'h0}, 0, 0, 0,
                           3'b000, 1, 32'hDEAD_BEEF, 0, 0, 32'h1234_5678);
        tbl[19] = tbl[18];
        tbl[19].rstN = 1'b0;
        tbl[20] = tbl[5];
        tbl[21] = mkRow(1, 3'b001, 12'h000, '0, 0, 1, 32'h55AA_55AA,
                        0, 0, 0, 0, 0, 0);
        tbl[22] = mkRow(0, 3'b001, 12'h000, '0, 0, 1, 32'h55AA_55AA,
                        3'b001, 0, 0, 1, 0, 0);
        tbl[23] = tbl[5];

        // Initial reset edge brings DUT and model to a known state
        applyStimulus(tbl[0]);
        advance();

        for (int i = 0; i < 24; i++) begin
            applyStimulus(tbl[i]);
            #3;
            checkRow(i, tbl[i]);
            checkOutput();
            advance();
        end

        // req0 and req1 stream writes continuously; check rotation pattern
        for (int c = 0; c < 20; c++) begin
            rstN = 1; cke = 1; valid = 3'b011; wstrb = 12'h0FF;
            wdata = {32'h0, 32'hB1B1_B1B1, 32'hB0B0_B0B0};
            treadyIn = 1; tvalidIn = 0; tdataIn = '0;
`ifdef IOB_AXIS_ARB_BURST_EN
            pos = c % (BMAX + 1);
            own = (c / (BMAX + 1)) % 2;
`else
            pos = c % 2;
            own = (c / 2) % 2;
`endif
            want = (pos == 0) ? 3'b000 : N'(1 << own);
            #3;
            checkSig($sformatf("burst.c%0d.ready_o", c), 32'(readyO), 32'(want));
            checkOutput();
            advance();
        end

        // Randomized traffic including clock-enable stalls and stray resets
        for (int c = 0; c < 1500; c++) begin
            rstN     = ($urandom_range(63) != 0);
            cke      = ($urandom_range(7) != 0);
            for (int k = 0; k < N; k++) begin
                valid[k]         = ($urandom_range(3) != 0);
                wstrb[k*4 +: 4]  = $urandom_range(1) ? 4'($urandom) : 4'h0;
                wdata[k*DW +: DW] = $urandom;
            end
            treadyIn = 1'($urandom);
            tvalidIn = 1'($urandom);
            tdataIn  = $urandom;
            #3;
            checkOutput();
            advance();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
